// File: rtl/wide_addsub_seq_pkg.sv
// rtl/wide_addsub_seq_pkg.sv - shared types and helpers for the chunked wide adder/subtractor
package wide_addsub_seq_pkg;

  localparam int WORD_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Carry out of a slice recovered from the operand MSBs and the sum MSB only.
  function automatic logic chunk_carry(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb & b_msb) | ((a_msb | b_msb) & ~s_msb);
  endfunction

  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/wide_addsub_seq_prefix_add16.sv
// rtl/wide_addsub_seq_prefix_add16.sv - combinational Kogge-Stone adder slice with carry in/out
module prefix_add16
  import wide_addsub_seq_pkg::*;
#(
  parameter int WIDTH = WORD_W_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  logic [WIDTH-1:0] gk;
  logic [WIDTH-1:0] pk;
  logic [WIDTH-1:0] gn;
  logic [WIDTH-1:0] pn;

  // ci is folded into bit 0's generate so the prefix tree yields carries directly.
  always_comb begin
    gk    = a & b;
    gk[0] = (a[0] & b[0]) | ((a[0] ^ b[0]) & ci);
    pk    = a ^ b;
    gn    = gk;
    pn    = pk;
    for (int d = 1; d < WIDTH; d = d * 2) begin
      gn = gk;
      pn = pk;
      for (int i = d; i < WIDTH; i++) begin
        gn[i] = gk[i] | (pk[i] & gk[i-d]);
        pn[i] = pk[i] & pk[i-d];
      end
      gk = gn;
      pk = pn;
    end
    s  = (a ^ b) ^ {gk[WIDTH-2:0], ci};
    co = chunk_carry(a[WIDTH-1], b[WIDTH-1], s[WIDTH-1]);
  end

endmodule

// File: rtl/wide_addsub_seq.sv
// rtl/wide_addsub_seq.sv - multi-cycle wide add/sub feeding one prefix slice a chunk per cycle
module wide_addsub_seq
  import wide_addsub_seq_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int NUM_WORDS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WORD_W*NUM_WORDS-1:0] in_a,
  input  logic [WORD_W*NUM_WORDS-1:0] in_b,
  input  logic                        in_sub,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORD_W*NUM_WORDS-1:0] out_sum,
  output logic                        out_cout,
  output logic                        out_ovf
);

  localparam int N     = WORD_W * NUM_WORDS;
  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  idx;
  logic              carry;
  logic [N-1:0]      opa;
  logic [N-1:0]      opb;
  logic [N-1:0]      acc;
  logic [N-1:0]      sum_nxt;
  logic [WORD_W-1:0] slice_a;
  logic [WORD_W-1:0] slice_b;
  logic [WORD_W-1:0] slice_s;
  logic              slice_co;
  logic              last;

  assign slice_a = opa[idx*WORD_W +: WORD_W];
  assign slice_b = opb[idx*WORD_W +: WORD_W];
  assign last    = (idx == LAST_IDX);

  prefix_add16 #(
    .WIDTH (WORD_W)
  ) u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  // Accumulator with the current chunk merged in; on the last chunk this is the full result.
  always_comb begin
    sum_nxt                         = acc;
    sum_nxt[idx*WORD_W +: WORD_W]   = slice_s;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      carry    <= 1'b0;
      opa      <= '0;
      opb      <= '0;
      acc      <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opa   <= in_a;
            opb   <= in_sub ? ~in_b : in_b;
            carry <= in_sub;
            idx   <= '0;
          end
        end
        RUN: begin
          acc   <= sum_nxt;
          carry <= slice_co;
          if (last) begin
            out_sum  <= sum_nxt;
            out_cout <= slice_co;
            out_ovf  <= signed_ovf(opa[N-1], opb[N-1], slice_s[WORD_W-1]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_addsub_seq.sv
// tb/tb_wide_addsub_seq.sv - self-checking bench for wide_addsub_seq against an arithmetic model
module tb_wide_addsub_seq;

  localparam int NW = 4;
  localparam int W  = 16;
  localparam int N  = W * NW;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  int total = 0;
  int bad   = 0;

  wide_addsub_seq #(
    .WORD_W    (W),
    .NUM_WORDS (NW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {ovf, cout, sum}; overflow from a wide signed result falling outside N-bit range.
  function automatic logic [N+1:0] model(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
    logic [N-1:0]   sum;
    logic           cout;
    logic [N+1:0]   sr;
    logic           ovf;
    if (sub) begin
      sum  = a - b;
      cout = (a >= b);
      sr   = {{2{a[N-1]}}, a} - {{2{b[N-1]}}, b};
    end else begin
      {cout, sum} = {1'b0, a} + {1'b0, b};
      sr   = {{2{a[N-1]}}, a} + {{2{b[N-1]}}, b};
    end
    ovf = (sr[N+1:N-1] != 3'b000) && (sr[N+1:N-1] != 3'b111);
    return {ovf, cout, sum};
  endfunction

  function automatic logic [N-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Issues one pair, scrambles the inputs after acceptance, and waits for out_valid.
  // lat counts edges from the accepting edge (inclusive) to the edge raising out_valid.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub, output int lat);
    int guard;
    guard = 0;
    lat   = 0;
    @(negedge clk);
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
      in_valid = 1'b0;
      lat = -1;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_a = rnd64(); in_b = rnd64(); in_sub = ~sub;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      total++; bad++;
      $display("FAIL result_timeout out_valid=%b required=1", out_valid);
      lat = -1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL reset_handshake got in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    total++;
    if ({out_ovf, out_cout, out_sum} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got sum=%h cout=%b ovf=%b required zeros", out_sum, out_cout, out_ovf);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
    int lat;
    logic [N+1:0] exp;
    exp = model(a, b, sub);
    run_op(a, b, sub, lat);
    total++;
    if ({out_ovf, out_cout, out_sum} !== exp) begin
      bad++;
      $display("FAIL %s got sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
               name, out_sum, out_cout, out_ovf, exp[N-1:0], exp[N], exp[N+1]);
    end
    total++;
    if (lat !== NW + 1) begin
      bad++;
      $display("FAIL %s_latency got=%0d required=%0d", name, lat, NW + 1);
    end
    @(negedge clk);
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL %s_release got out_valid=%b in_ready=%b required 0 1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_full_ripple();
    out_ready = 1'b1;
    check_op("full_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
  endtask

  task automatic test_borrow();
    out_ready = 1'b1;
    check_op("borrow_0m1", 64'h0, 64'h1, 1'b1);
    check_op("borrow_5m3", 64'h5, 64'h3, 1'b1);
  endtask

  task automatic test_signed_ovf();
    out_ready = 1'b1;
    check_op("ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    check_op("ovf_sub", 64'h8000_0000_0000_0000, 64'h1, 1'b1);
  endtask

  task automatic test_backpressure();
    int lat;
    logic [N+1:0] exp;
    logic [N-1:0] a;
    logic [N-1:0] b;
    a = 64'h0000_0001_0000_FFFF;
    b = 64'h0000_0000_0000_0001;
    exp = model(a, b, 1'b0);
    out_ready = 1'b0;
    run_op(a, b, 1'b0, lat);
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({out_valid, in_ready, out_ovf, out_cout, out_sum} !== {2'b10, exp}) begin
        bad++;
        $display("FAIL backpressure_hold cyc=%0d got v=%b r=%b sum=%h cout=%b ovf=%b required v=1 r=0 sum=%h",
                 i, out_valid, in_ready, out_sum, out_cout, out_ovf, exp[N-1:0]);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL backpressure_release got out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    out_ready = 1'b1;
    @(negedge clk);
    in_a = 64'h1234_5678_9ABC_DEF0; in_b = 64'h1234_5678_9ABC_DEF0; in_sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, out_ovf, out_cout, out_sum} !== {2'b10, {(N+2){1'b0}}}) begin
      bad++;
      $display("FAIL reset_mid_run got r=%b v=%b sum=%h cout=%b ovf=%b required r=1 v=0 zeros",
               in_ready, out_valid, out_sum, out_cout, out_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_result got out_valid seen=%b required 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] a [3];
    logic [N-1:0] b [3];
    logic         s [3];
    logic [N+1:0] expq[$];
    logic [N+1:0] exp;
    int           acc_cyc [3];
    int           sent;
    int           got;
    int           cyc;
    bit           pending;
    sent = 0; got = 0; cyc = 0; pending = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a[i] = rnd64();
      b[i] = rnd64();
      s[i] = (i == 1);
      acc_cyc[i] = 0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_a = a[0]; in_b = b[0]; in_sub = s[0]; in_valid = 1'b1;
    while (got < 3 && cyc < 100) begin
      if (pending) begin
        pending = 1'b0;
        if (sent < 3) begin
          in_a = a[sent]; in_b = b[sent]; in_sub = s[sent];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        exp = expq.pop_front();
        total++;
        if ({out_ovf, out_cout, out_sum} !== exp) begin
          bad++;
          $display("FAIL b2b_result%0d got sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                   got, out_sum, out_cout, out_ovf, exp[N-1:0], exp[N], exp[N+1]);
        end
        got++;
      end
      if (in_ready && in_valid && sent < 3) begin
        acc_cyc[sent] = cyc;
        expq.push_back(model(a[sent], b[sent], s[sent]));
        sent++;
        pending = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    total++;
    if (got !== 3) begin
      bad++;
      $display("FAIL b2b_count got=%0d required=3", got);
    end
    for (int i = 1; i < 3; i++) begin
      total++;
      if (acc_cyc[i] - acc_cyc[i-1] !== NW + 2) begin
        bad++;
        $display("FAIL b2b_interval%0d got=%0d required=%0d", i, acc_cyc[i] - acc_cyc[i-1], NW + 2);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_op($sformatf("random%0d", i), rnd64(), rnd64(), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_full_ripple();
    test_borrow();
    test_signed_ovf();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wide_addsub_seq.md
Name: wide_addsub_seq

Overview:
- Multi-cycle wide adder/subtractor that sits directly upstream of, and drives, the 16-bit parallel-prefix adder slice.
- It latches one wide operand pair through a valid/ready handshake.
- It feeds the slice one WORD_W-bit chunk per cycle, LSB chunk first, and chains the carry between chunks in a register.
- It returns the full-width sum, carry-out and signed overflow through a valid/ready output handshake.

Parameters:
- WORD_W, 16, width of one chunk; equals the prefix adder slice width.
- NUM_WORDS, 4, chunks per operand; total width N = WORD_W*NUM_WORDS, default 64. Legal range 2..16.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- in_a  in  N  operand A.
- in_b  in  N  operand B.
- in_sub  in  1  1 = A-B, 0 = A+B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  N  result, mod 2^N.
- out_cout  out  1  carry-out of bit N-1; for subtract, 1 = no borrow (A >= B unsigned).
- out_ovf  out  1  two's-complement signed overflow.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, chunk index=0, carry register=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: register in_a into opa.
  - Register b_eff (in_b, or ~in_b if in_sub) into opb.
  - Set carry = in_sub, idx = 0; go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle, the slice computes {co, s} = opa[idx] + opb[idx] + carry, all WORD_W-bit chunks.
  - s is written into sum chunk idx; carry <= co.
  - If idx == NUM_WORDS-1: record cout = co, go to DONE. Otherwise idx++.
- Overflow: computed at the final chunk as (opa[N-1] == opb[N-1]) && (s[WORD_W-1] != opa[N-1]); registered into out_ovf.
- DONE:
  - out_valid=1; out_sum, out_cout and out_ovf are stable and held while out_ready=0.
  - On out_ready=1: go to IDLE, deassert out_valid on the next edge.
  - No input is accepted in DONE.
- Latency: out_valid rises NUM_WORDS+1 edges after the accepting edge (default 5). Minimum issue interval is NUM_WORDS+2 cycles with out_ready held high.
- Output registers update only on the final RUN cycle; intermediate sum chunks are kept in an internal accumulator. out_* therefore keep the previous result until the new one completes.
- Inputs in_a, in_b and in_sub are sampled only on the accepting edge; later changes have no effect.
- Wrap-around: the sum is mod 2^N; a carry out of the top chunk appears only on out_cout.
- Reset mid-operation: asserting rst_n low in RUN or DONE immediately forces reset values (asynchronous). The partial result is discarded and no out_valid is produced.
- in_valid asserted while not in IDLE is ignored; the upstream source must hold it.
- Carry-out of a slice is derived as (a_msb & b_msb) | ((a_msb | b_msb) & ~s_msb) when the slice exposes only the sum.

Decomposition:
- Shared package: WORD_W default; the FSM state enum (IDLE, RUN, DONE); a function for the chunk-carry expression; a function for the signed-overflow expression.
- One sub-module, prefix_add16: a 16-bit prefix-network slice with separate a, b, ci inputs and s, co outputs.
  - It is purely combinational and instantiated once.
  - b inversion is done in this block, not inside the slice.

Test Plan:
- Full ripple: A=0x0000_0000_0000_FFFF... set A=0xFFFF_FFFF_FFFF_FFFF, B=1, add -> out_sum=0, out_cout=1, out_ovf=0, out_valid exactly 5 cycles after accept.
- Borrow: A=0, B=1, sub -> out_sum=0xFFFF_FFFF_FFFF_FFFF, out_cout=0, out_ovf=0. Then A=5, B=3, sub -> out_sum=2, out_cout=1.
- Signed overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=1, add -> out_sum=0x8000_0000_0000_0000, out_ovf=1, out_cout=0. Then A=0x8000_0000_0000_0000, B=1, sub -> out_sum=0x7FFF_FFFF_FFFF_FFFF, out_ovf=1.
- Backpressure: A=0x0000_0001_0000_FFFF, B=0x0000_0000_0000_0001, add with out_ready=0 for 10 cycles -> out_valid and out_sum=0x0000_0001_0001_0000 stay stable and in_ready=0. Release out_ready -> in_ready=1 one cycle after the handshake.
- Reset mid-RUN: accept A=B=0x1234_5678_9ABC_DEF0, pull rst_n low in the 2nd RUN cycle -> all outputs return to reset values immediately, with no out_valid afterwards.
- Back-to-back: in_valid and out_ready held high with three random pairs (add, sub, add) -> three results match the reference model, with an issue interval of 6 cycles each.
